// File: rtl/clock_time_core_pkg.sv
// Shared types and BCD limits for the time-of-day engine.
package clock_pkg;

   typedef enum logic {
      MODE_RUN = 1'b0,
      MODE_SET = 1'b1
   } mode_e;

   localparam logic [7:0] HOUR_MAX = 8'h23;
   localparam logic [7:0] MIN_MAX  = 8'h59;
   localparam logic [7:0] SEC_MAX  = 8'h59;

   // Next value of a packed two-digit BCD counter that wraps to 00 after max.
   function automatic logic [7:0] bcd2_next(input logic [7:0] v, input logic [7:0] max);
      if (v == max)
         return 8'h00;
      else if (v[3:0] >= 4'd9)
         return {v[7:4] + 4'd1, 4'h0};
      else
         return v + 8'd1;
   endfunction

endpackage

// File: rtl/clock_time_core_if.sv
// Key inputs and display-facing outputs of the time-of-day engine.
interface clock_time_core_if;

   logic       key_mode;
   logic       key_inc_h;
   logic       key_inc_m;
   logic [3:0] h_cntH;
   logic [3:0] h_cntL;
   logic [3:0] m_cntH;
   logic [3:0] m_cntL;
   logic [3:0] s_cntH;
   logic [3:0] s_cntL;
   logic [7:0] set_h;
   logic [7:0] set_m;
   logic       mode;
   logic       scan_en;

   modport master (
      output key_mode, key_inc_h, key_inc_m,
      input  h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL,
      input  set_h, set_m, mode, scan_en
   );

   modport slave (
      input  key_mode, key_inc_h, key_inc_m,
      output h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL,
      output set_h, set_m, mode, scan_en
   );

endinterface

// File: rtl/clock_time_core_bcd2_counter.sv
// Two-digit packed-BCD counter wrapping at MAX; a load overrides an increment.
module bcd2_counter
   import clock_pkg::*;
#(
   parameter logic [7:0] MAX = 8'h59
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] q,
   output logic       carry
);

   logic [7:0] q_q;
   logic [7:0] q_d;

   always_comb begin
      // NOTE: q_d takes its hold value first, so no path leaves it unassigned and no latch is inferred.
      q_d = q_q;
      if (load)
         q_d = load_val;
      else if (inc)
         q_d = bcd2_next(q_q, MAX);
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn)
         q_q <= 8'h00;
      else
         q_q <= q_d;
   end

   assign q     = q_q;
   assign carry = inc && (q_q == MAX);

endmodule

// File: rtl/clock_time_core.sv
// BCD time-of-day engine: second prescaler, scan strobe, time counters and RUN/SET preset editor.
module clock_time_core
   import clock_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int SCAN_DIV = 50_000
) (
   input  logic              clk,
   input  logic              rstn,
   clock_time_core_if.slave  bus
);

   localparam int PW = $clog2(CLK_FREQ);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

   mode_e         state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [SW-1:0] scan_cnt_q, scan_cnt_d;
   logic          scan_en_q, scan_en_d;

   logic       tick;
   logic       load_time;
   logic       load_preset;
   logic       inc_set_h;
   logic       inc_set_m;
   logic       sec_carry;
   logic       min_carry;
   logic       hour_carry_unused;
   logic       set_h_carry_unused;
   logic       set_m_carry_unused;
   logic [7:0] hour_q, min_q, sec_q, set_h_q, set_m_q;

   always_comb begin
      state_d     = state_q;
      load_time   = 1'b0;
      load_preset = 1'b0;
      inc_set_h   = 1'b0;
      inc_set_m   = 1'b0;
      tick        = (presc_q == PRESC_LAST);
      presc_d     = tick ? '0 : presc_q + PW'(1);
      scan_cnt_d  = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SW'(1);
      scan_en_d   = (scan_cnt_d == SCAN_LAST);

      case (state_q)
         MODE_RUN: begin
            if (bus.key_mode) begin
               state_d     = MODE_SET;
               load_preset = 1'b1;
            end
         end
         MODE_SET: begin
            // Leaving SET restarts the second from zero; the counter load masks any tick due now.
            if (bus.key_mode) begin
               state_d   = MODE_RUN;
               load_time = 1'b1;
               presc_d   = '0;
            end else begin
               inc_set_h = bus.key_inc_h;
               inc_set_m = bus.key_inc_m;
            end
         end
         default: state_d = MODE_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= MODE_RUN;
         presc_q    <= '0;
         scan_cnt_q <= '0;
         scan_en_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         scan_cnt_q <= scan_cnt_d;
         scan_en_q  <= scan_en_d;
      end
   end

   bcd2_counter #(.MAX(SEC_MAX)) u_sec (
      .clk(clk), .rstn(rstn), .inc(tick), .load(load_time), .load_val(8'h00),
      .q(sec_q), .carry(sec_carry)
   );

   bcd2_counter #(.MAX(MIN_MAX)) u_min (
      .clk(clk), .rstn(rstn), .inc(sec_carry), .load(load_time), .load_val(set_m_q),
      .q(min_q), .carry(min_carry)
   );

   bcd2_counter #(.MAX(HOUR_MAX)) u_hour (
      .clk(clk), .rstn(rstn), .inc(min_carry), .load(load_time), .load_val(set_h_q),
      .q(hour_q), .carry(hour_carry_unused)
   );

   // Presets capture the pre-advance time register, so a coinciding tick never leaks in.
   bcd2_counter #(.MAX(HOUR_MAX)) u_set_h (
      .clk(clk), .rstn(rstn), .inc(inc_set_h), .load(load_preset), .load_val(hour_q),
      .q(set_h_q), .carry(set_h_carry_unused)
   );

   bcd2_counter #(.MAX(MIN_MAX)) u_set_m (
      .clk(clk), .rstn(rstn), .inc(inc_set_m), .load(load_preset), .load_val(min_q),
      .q(set_m_q), .carry(set_m_carry_unused)
   );

   assign bus.h_cntH  = hour_q[7:4];
   assign bus.h_cntL  = hour_q[3:0];
   assign bus.m_cntH  = min_q[7:4];
   assign bus.m_cntL  = min_q[3:0];
   assign bus.s_cntH  = sec_q[7:4];
   assign bus.s_cntL  = sec_q[3:0];
   assign bus.set_h   = set_h_q;
   assign bus.set_m   = set_m_q;
   assign bus.mode    = state_q;
   assign bus.scan_en = scan_en_q;

endmodule
